spi_rcbuf_ctrl: RTL and testbench

- Controller and arbiter for the single-port receive byte RAM that sits behind spiifc.
- Shares the RAM between spiifc's MOSI byte writes, which are never stalled, and a host-side read port.
- Tracks buffer ownership per SPI packet (SS low to SS high), reports packet length, and flags overrun when the host has not yet released the previous packet.

---
 rtl/spi_rcbuf_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_spi_rcbuf_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rcbuf_ctrl.sv
// Receive-buffer controller: arbitrates the single-port SPI receive RAM between
//   spiifc byte writes (zero latency, never stalled) and host reads (ack 2 cycles after accept).
// Backpressure: none on SPI (writes dropped + overrun while FULL); host reads retry while a write collides.
module spi_rcbuf_ctrl #(
    parameter int AddrBits = 12
) (
    input  logic                SysClk,
    input  logic                Reset,
    input  logic                SPI_SS,
    input  logic [AddrBits-1:0] rcMemAddr,
    input  logic [7:0]          rcMemData,
    input  logic                rcMemWE,
    output logic [AddrBits-1:0] memAddr,
    output logic [7:0]          memData,
    output logic                memWE,
    input  logic [7:0]          memRdData,
    input  logic                hostReq,
    input  logic [AddrBits-1:0] hostAddr,
    output logic                hostAck,
    output logic [7:0]          hostData,
    output logic                pktValid,
    output logic [AddrBits:0]   pktLen,
    input  logic                pktRelease,
    output logic                overrun
);

    // Byte count saturates at a full buffer (2^AddrBits), hence one extra bit.
    localparam logic [AddrBits:0] CntMax = {1'b1, {AddrBits{1'b0}}};
    localparam logic [AddrBits:0] CntOne = {{AddrBits{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_ss_meta;
    logic                r_ss_sync;
    logic                r_ss_prev;
    logic                w_ss_rise;

    logic [AddrBits:0]   r_cnt;
    logic [AddrBits:0]   w_cnt_inc;
    logic [AddrBits:0]   r_pkt_len;
    logic                r_pkt_vld;
    logic                r_overrun;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_release;

    logic                r_rd_s1;
    logic                r_ack;
    logic [7:0]          r_host_dat;

    // SS synchroniser; resets high (deselected) so reset release never looks like a packet end
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            r_ss_meta <= 1'b1;
            r_ss_sync <= 1'b1;
            r_ss_prev <= 1'b1;
        end else begin
            r_ss_meta <= SPI_SS;
            r_ss_sync <= r_ss_meta;
            r_ss_prev <= r_ss_sync;
        end
    end

    assign w_ss_rise = r_ss_sync & ~r_ss_prev;

    // FSM state register
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a packet only becomes FULL if it carried at least one byte
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_acc) begin
                    w_state_nxt = ST_FILLING;
                end
            end
            ST_FILLING: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pktRelease) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs and RAM port mux: SPI write always wins, host read takes idle slots only
    always_comb begin
        w_wr_acc  = rcMemWE & (r_state != ST_FULL);
        w_release = pktRelease & (r_state == ST_FULL);
        w_rd_acc  = hostReq & ~r_rd_s1 & ~r_ack & ~w_wr_acc;
        memWE     = w_wr_acc;
        memData   = rcMemData;
        memAddr   = w_rd_acc ? hostAddr : rcMemAddr;
    end

    assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : (r_cnt + CntOne);

    // Packet bookkeeping: byte count, latched length, ownership flag, sticky overrun
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            r_cnt     <= '0;
            r_pkt_len <= '0;
            r_pkt_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_acc) begin
                        r_cnt <= CntOne;
                    end
                end
                ST_FILLING: begin
                    if (w_wr_acc) begin
                        r_cnt <= w_cnt_inc;
                    end
                    if (w_ss_rise) begin
                        r_pkt_len <= w_wr_acc ? w_cnt_inc : r_cnt;
                        r_pkt_vld <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // Release wins over a same-cycle write: that write is dropped silently.
                    if (w_release) begin
                        r_cnt     <= '0;
                        r_pkt_len <= '0;
                        r_pkt_vld <= 1'b0;
                        r_overrun <= 1'b0;
                    end else if (rcMemWE) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Host read pipeline: address at T, RAM data at T+1 captured, ack pulse at T+2
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            r_rd_s1    <= 1'b0;
            r_ack      <= 1'b0;
            r_host_dat <= 8'h00;
        end else begin
            r_rd_s1 <= w_rd_acc;
            r_ack   <= r_rd_s1;
            if (r_rd_s1) begin
                r_host_dat <= memRdData;
            end
        end
    end

    assign hostAck  = r_ack;
    assign hostData = r_host_dat;
    assign pktValid = r_pkt_vld;
    assign pktLen   = r_pkt_len;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_rcbuf_ctrl.sv
// Self-checking bench for spi_rcbuf_ctrl with a behavioural single-port RAM;
//   host read results go through an expected-data queue popped on hostAck.
module tb_spi_rcbuf_ctrl;

    localparam int AW = 12;

    logic          SysClk = 1'b0;
    logic          Reset;
    logic          SPI_SS;
    logic [AW-1:0] rcMemAddr;
    logic [7:0]    rcMemData;
    logic          rcMemWE;
    logic [AW-1:0] memAddr;
    logic [7:0]    memData;
    logic          memWE;
    logic [7:0]    memRdData;
    logic          hostReq;
    logic [AW-1:0] hostAddr;
    logic          hostAck;
    logic [7:0]    hostData;
    logic          pktValid;
    logic [AW:0]   pktLen;
    logic          pktRelease;
    logic          overrun;

    logic [7:0]    ram [0:(1<<AW)-1];
    logic [7:0]    sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_we  = 0;
    int            n_ack = 0;

    spi_rcbuf_ctrl #(.AddrBits(AW)) dut (
        .SysClk(SysClk), .Reset(Reset), .SPI_SS(SPI_SS),
        .rcMemAddr(rcMemAddr), .rcMemData(rcMemData), .rcMemWE(rcMemWE),
        .memAddr(memAddr), .memData(memData), .memWE(memWE), .memRdData(memRdData),
        .hostReq(hostReq), .hostAddr(hostAddr), .hostAck(hostAck), .hostData(hostData),
        .pktValid(pktValid), .pktLen(pktLen), .pktRelease(pktRelease), .overrun(overrun)
    );

    always #5 SysClk = ~SysClk;

    // Single-port RAM: write-first not needed, read data registered one cycle
    always @(posedge SysClk) begin
        if (memWE) ram[memAddr] <= memData;
        memRdData <= ram[memAddr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 ns after the falling edge; the monitor samples exactly on it.
    task automatic tick();
        @(negedge SysClk);
        #1;
    endtask

    always @(negedge SysClk) begin
        if (memWE) n_we++;
        if (hostAck) begin
            n_ack++;
            check_val("ack_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check_val("hostData", 32'(hostData), 32'(sb_q.pop_front()));
        end
    end

    // Issue one host read; optionally collide with an SPI write of d to the same address.
    task automatic do_read(input logic [AW-1:0] a, input logic [7:0] d, input logic wr);
        int lat;
        hostReq  = 1'b1;
        hostAddr = a;
        if (wr) begin
            rcMemWE   = 1'b1;
            rcMemAddr = a;
            rcMemData = d;
        end
        sb_q.push_back(d);
        #1;
        check_val("rd_t0_memAddr", 32'(memAddr), 32'(a));
        check_val("rd_t0_memWE", 32'(memWE), 32'(wr));
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1 && wr) begin
                rcMemWE = 1'b0;
                #1;
                check_val("rd_retry_memAddr", 32'(memAddr), 32'(a));
            end
            if (hostAck) begin
                lat = k;
                break;
            end
        end
        check_val("rd_latency", 32'(lat), 32'(2 + int'(wr)));
        hostReq = 1'b0;
        tick();
        check_val("ack_one_cycle", 32'(hostAck), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        Reset = 1'b1; SPI_SS = 1'b1; rcMemAddr = 12'h123; rcMemData = 8'h00; rcMemWE = 1'b0;
        hostReq = 1'b0; hostAddr = '0; pktRelease = 1'b0;
        tick(); tick();
        check_val("rst_hostAck", 32'(hostAck), 32'd0);
        check_val("rst_hostData", 32'(hostData), 32'd0);
        check_val("rst_pktValid", 32'(pktValid), 32'd0);
        check_val("rst_pktLen", 32'(pktLen), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_memWE", 32'(memWE), 32'd0);
        check_val("rst_memAddr", 32'(memAddr), 32'h123);
        Reset = 1'b0;
        tick(); tick();

        // Packet of four bytes
        SPI_SS = 1'b0;
        repeat (3) tick();
        n_we = 0;
        for (int i = 0; i < 4; i++) begin
            rcMemWE = 1'b1; rcMemAddr = AW'(i); rcMemData = 8'(8'hA1 + i);
            #1;
            check_val("wr_memWE", 32'(memWE), 32'd1);
            check_val("wr_memAddr", 32'(memAddr), 32'(i));
            tick();
        end
        rcMemWE = 1'b0;
        check_val("wr_pulses", 32'(n_we), 32'd4);
        check_val("filling_pktValid", 32'(pktValid), 32'd0);
        SPI_SS = 1'b1;
        tick(); tick();
        check_val("ss_edge2_pktValid", 32'(pktValid), 32'd0);
        tick();
        check_val("ss_edge3_pktValid", 32'(pktValid), 32'd1);
        check_val("pkt1_pktLen", 32'(pktLen), 32'd4);
        check_val("pkt1_overrun", 32'(overrun), 32'd0);

        // Host reads from FULL
        do_read(12'd2, 8'hA3, 1'b0);
        do_read(12'd0, 8'hA1, 1'b0);

        // Overrun while FULL, then release beating a same-cycle write
        rcMemWE = 1'b1; rcMemAddr = 12'd0; rcMemData = 8'hFF;
        #1;
        check_val("full_memWE", 32'(memWE), 32'd0);
        tick();
        rcMemWE = 1'b0;
        check_val("overrun_set", 32'(overrun), 32'd1);
        tick();
        check_val("overrun_sticky", 32'(overrun), 32'd1);
        check_val("full_pktLen", 32'(pktLen), 32'd4);
        do_read(12'd0, 8'hA1, 1'b0);
        pktRelease = 1'b1; rcMemWE = 1'b1; rcMemAddr = 12'd0; rcMemData = 8'hEE;
        #1;
        check_val("release_memWE", 32'(memWE), 32'd0);
        tick();
        pktRelease = 1'b0; rcMemWE = 1'b0;
        check_val("release_pktValid", 32'(pktValid), 32'd0);
        check_val("release_pktLen", 32'(pktLen), 32'd0);
        check_val("release_overrun", 32'(overrun), 32'd0);
        do_read(12'd0, 8'hA1, 1'b0);

        // Read colliding with a write in IDLE; release ignored while FILLING
        SPI_SS = 1'b0;
        repeat (3) tick();
        do_read(12'd5, 8'h5A, 1'b1);
        pktRelease = 1'b1;
        tick();
        pktRelease = 1'b0;
        SPI_SS = 1'b1;
        repeat (4) tick();
        check_val("pkt2_pktValid", 32'(pktValid), 32'd1);
        check_val("pkt2_pktLen", 32'(pktLen), 32'd1);
        pktRelease = 1'b1;
        tick();
        pktRelease = 1'b0;
        check_val("pkt2_released", 32'(pktValid), 32'd0);

        // Empty SS pulse, then a saturating packet
        SPI_SS = 1'b0;
        repeat (4) tick();
        SPI_SS = 1'b1;
        repeat (5) tick();
        check_val("empty_pkt_valid", 32'(pktValid), 32'd0);
        check_val("empty_pkt_len", 32'(pktLen), 32'd0);
        SPI_SS = 1'b0;
        repeat (3) tick();
        n_we = 0;
        for (int i = 0; i < (1 << AW) + 3; i++) begin
            rcMemWE = 1'b1; rcMemAddr = AW'(i); rcMemData = 8'(i);
            tick();
        end
        rcMemWE = 1'b0;
        check_val("sat_wr_pulses", 32'(n_we), 32'((1 << AW) + 3));
        tick();
        SPI_SS = 1'b1;
        repeat (4) tick();
        check_val("sat_pktValid", 32'(pktValid), 32'd1);
        check_val("sat_pktLen", 32'(pktLen), 32'(1 << AW));

        // Reset one cycle after a read is accepted
        hostReq = 1'b1; hostAddr = 12'd3;
        tick();
        snap = n_ack;
        Reset = 1'b1;
        #1;
        check_val("midrd_hostData", 32'(hostData), 32'd0);
        check_val("midrd_pktValid", 32'(pktValid), 32'd0);
        check_val("midrd_pktLen", 32'(pktLen), 32'd0);
        check_val("midrd_overrun", 32'(overrun), 32'd0);
        hostReq = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        repeat (5) tick();
        check_val("midrd_no_ack", 32'(n_ack - snap), 32'd0);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
